// File: rtl/conv_cfg_pkg.sv
// Shared types for the conv_kernel frame/config controller: FSM encoding,
// coefficient index type and the identity-kernel generator.
package conv_cfg_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } cfg_state_e;

  typedef logic [7:0] coef_idx_t;

  // Upper bound on SIZE*SIZE*KERNEL_WIDTH for the identity-kernel helper.
  localparam int MAX_KERNEL_BITS = 1024;

  // Identity kernel: centre coefficient = +1, all others 0, index 0 in the LSBs.
  function automatic logic [MAX_KERNEL_BITS-1:0] identity_kernel(input int size, input int kw);
    logic [MAX_KERNEL_BITS-1:0] k;
    k = '0;
    k[((size * size) / 2) * kw] = 1'b1;
    return k;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster position tracker for the conv_kernel pixel stream: row/col of the
// next beat plus the combinational sof/eol/eof beat qualifiers.
module raster_counter #(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int POS_WIDTH = 13
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 pix_valid_i,
  output logic [POS_WIDTH-1:0] row_o,
  output logic [POS_WIDTH-1:0] col_o,
  output logic                 sof_o,
  output logic                 eol_o,
  output logic                 eof_o
);

  localparam logic [POS_WIDTH-1:0] COL_LAST = POS_WIDTH'(WIDTH - 1);
  localparam logic [POS_WIDTH-1:0] ROW_LAST = POS_WIDTH'(HEIGHT - 1);

  logic [POS_WIDTH-1:0] row_q;
  logic [POS_WIDTH-1:0] col_q;
  logic                 line_end;
  logic                 last_row;

  assign line_end = (col_q == COL_LAST);
  assign last_row = (row_q == ROW_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_q <= '0;
      col_q <= '0;
    end else if (pix_valid_i) begin
      if (line_end) begin
        col_q <= '0;
        row_q <= last_row ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  assign row_o = row_q;
  assign col_o = col_q;
  assign sof_o = pix_valid_i && (row_q == '0) && (col_q == '0);
  assign eol_o = pix_valid_i && line_end;
  assign eof_o = eol_o && last_row;

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer and coefficient shadow/active controller for conv_kernel.
// Optional stats (frame_cnt_o, cfg_drop_o) are built when CONV_FRAME_CTRL_STATS_EN is defined.
module conv_frame_ctrl
  import conv_cfg_pkg::*;
#(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int SIZE         = 3,
  parameter int KERNEL_WIDTH = 4,
  parameter int NORM_WIDTH   = 4,
  parameter int POS_WIDTH    = 13
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              pix_valid_i,
  input  logic                              cfg_wr_i,
  input  logic [7:0]                        cfg_idx_i,
  input  logic [KERNEL_WIDTH-1:0]           cfg_data_i,
  input  logic                              cfg_norm_wr_i,
  input  logic [NORM_WIDTH-1:0]             cfg_norm_i,
  input  logic                              cfg_commit_i,
  output logic                              cfg_busy_o,
  output logic [SIZE*SIZE*KERNEL_WIDTH-1:0] kernel_o,
  output logic [NORM_WIDTH-1:0]             norm_o,
  output logic [POS_WIDTH-1:0]              row_o,
  output logic [POS_WIDTH-1:0]              col_o,
  output logic                              sof_o,
  output logic                              eol_o,
  output logic                              eof_o,
  output logic [15:0]                       frame_cnt_o,
  output logic                              cfg_drop_o,
  output cfg_state_e                        fsm_state_o
);

  localparam int NUM_COEF    = SIZE * SIZE;
  localparam int KERNEL_BITS = NUM_COEF * KERNEL_WIDTH;
  localparam logic [MAX_KERNEL_BITS-1:0] IDENT_FULL = identity_kernel(SIZE, KERNEL_WIDTH);
  localparam logic [KERNEL_BITS-1:0]     IDENT      = IDENT_FULL[KERNEL_BITS-1:0];
  localparam logic [NORM_WIDTH-1:0]      NORM_ONE   = NORM_WIDTH'(1);

  cfg_state_e             state_q;
  cfg_state_e             state_d;
  logic [KERNEL_BITS-1:0] shadow_q;
  logic [KERNEL_BITS-1:0] shadow_d;
  logic [KERNEL_BITS-1:0] active_q;
  logic [NORM_WIDTH-1:0]  shadow_norm_q;
  logic [NORM_WIDTH-1:0]  shadow_norm_d;
  logic [NORM_WIDTH-1:0]  active_norm_q;
  logic                   between_frames;
  logic                   idle_start;
  logic                   wr_accept;
  logic                   norm_accept;
  logic                   apply;

  raster_counter #(
    .WIDTH    (WIDTH),
    .HEIGHT   (HEIGHT),
    .POS_WIDTH(POS_WIDTH)
  ) u_raster (
    .clk        (clk),
    .reset_n    (reset_n),
    .pix_valid_i(pix_valid_i),
    .row_o      (row_o),
    .col_o      (col_o),
    .sof_o      (sof_o),
    .eol_o      (eol_o),
    .eof_o      (eof_o)
  );

  // Nothing in flight: at the raster origin with no beat this cycle.
  assign between_frames = (row_o == '0) && (col_o == '0) && !pix_valid_i;
  assign idle_start     = cfg_commit_i && between_frames;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state; a commit on an eof beat in IDLE waits for the following eof
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_commit_i && !idle_start) state_d = PENDING;
      PENDING: if (eof_o) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    wr_accept   = 1'b0;
    norm_accept = 1'b0;
    apply       = 1'b0;
    cfg_busy_o  = 1'b0;
    case (state_q)
      IDLE: begin
        wr_accept   = cfg_wr_i;
        norm_accept = cfg_norm_wr_i;
        apply       = idle_start;
      end
      PENDING: begin
        apply      = eof_o;
        cfg_busy_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Shadow next value; out-of-range indices match no slot and fall away.
  for (genvar k = 0; k < NUM_COEF; k++) begin : g_coef
    assign shadow_d[k*KERNEL_WIDTH +: KERNEL_WIDTH] =
      (wr_accept && (cfg_idx_i == coef_idx_t'(k))) ? cfg_data_i
                                                   : shadow_q[k*KERNEL_WIDTH +: KERNEL_WIDTH];
  end

  assign shadow_norm_d = !norm_accept         ? shadow_norm_q :
                         (cfg_norm_i == '0)   ? NORM_ONE      : cfg_norm_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q      <= IDENT;
      shadow_norm_q <= NORM_ONE;
    end else begin
      shadow_q      <= shadow_d;
      shadow_norm_q <= shadow_norm_d;
    end
  end

  // Active bank loads from shadow_d so a same-cycle write is part of the commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q      <= IDENT;
      active_norm_q <= NORM_ONE;
    end else if (apply) begin
      active_q      <= shadow_d;
      active_norm_q <= shadow_norm_d;
    end
  end

  assign kernel_o    = active_q;
  assign norm_o      = active_norm_q;
  assign fsm_state_o = state_q;

`ifdef CONV_FRAME_CTRL_STATS_EN
  logic [15:0] frame_cnt_q;
  logic        cfg_drop_q;
  logic        drop_evt;

  assign drop_evt = (state_q == PENDING) && (cfg_wr_i || cfg_norm_wr_i);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
      cfg_drop_q  <= 1'b0;
    end else begin
      if (eof_o)    frame_cnt_q <= frame_cnt_q + 16'd1;
      if (drop_evt) cfg_drop_q  <= 1'b1;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign cfg_drop_o  = cfg_drop_q;
`else
  assign frame_cnt_o = '0;
  assign cfg_drop_o  = 1'b0;
`endif

endmodule
